// File: rtl/seq_mul_pkg.sv
// Shared arithmetic definitions for the sequential multiplier and divider.
// Holds the controller state encoding, default width and counter sizing.
package seq_mul_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int W_DEF = 4;

  // Iteration counter must hold values 0..W.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul.sv
// Unsigned shift-and-add multiplier: one partial-product bit per clock,
// start/done handshake matching the non-restoring divider.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CW = cnt_width(W);

  state_t          state;
  logic [W-1:0]    mcand;
  logic [2*W:0]    acc;
  logic [2*W:0]    acc_added;
  logic [2*W:0]    acc_next;
  logic [W:0]      sum;
  logic [CW-1:0]   cnt;
  logic            last;

  // Upper half plus carry absorbs the multiplicand, then everything shifts right.
  always_comb begin
    sum       = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
    acc_added = acc;
    if (acc[0]) begin
      acc_added = {sum, acc[W-1:0]};
    end
    acc_next  = {1'b0, acc_added[2*W:1]};
  end

  assign last = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= x;
            acc   <= {{(W + 1){1'b0}}, y};
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            p     <= acc_next[2*W-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul (W=4): directed cases, handshake corners,
// mid-run reset, random traffic and an exhaustive back-to-back sweep.
module tb_seq_mul;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int checks;
  int failures;

  seq_mul #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation and waits (bounded) for done; inputs change and
  // outputs are sampled 1ns after each rising edge.
  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input bit hold,
                        output int cycles, output int busy_cycles, output logic [2*W-1:0] pr);
    x = xv;
    y = yv;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    busy_cycles = busy ? 1 : 0;
    cycles = 0;
    while (cycles < 20) begin
      if (hold) begin
        x = W'($urandom);
        y = W'($urandom);
      end
      @(posedge clk);
      #1;
      cycles++;
      if (done) break;
      if (busy) busy_cycles++;
    end
    pr = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    y = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state: busy=%b done=%b p=%h, required busy=0 done=0 p=00", busy, done, p);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] xs [5] = '{4'd15, 4'd13, 4'd0, 4'd1, 4'd9};
    logic [W-1:0] ys [5] = '{4'd15, 4'd11, 4'd9, 4'd15, 4'd0};
    int cyc, bcyc;
    logic [2*W-1:0] pr;
    int expected;
    for (int i = 0; i < 5; i++) begin
      expected = int'(xs[i]) * int'(ys[i]);
      run_op(xs[i], ys[i], 1'b0, cyc, bcyc, pr);
      checks++;
      if (cyc != W) begin
        failures++;
        $display("[TB] FAIL directed_latency %0d*%0d: got %0d cycles, required %0d", xs[i], ys[i], cyc, W);
      end
      checks++;
      if (pr !== 8'(expected)) begin
        failures++;
        $display("[TB] FAIL directed_product %0d*%0d: got %0d, required %0d", xs[i], ys[i], pr, expected);
      end
      checks++;
      if (bcyc != W || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL directed_busy %0d*%0d: busy cycles %0d busy_at_done=%b, required %0d and 0", xs[i], ys[i], bcyc, busy, W);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL directed_done_width %0d*%0d: done=%b one cycle later, required 0", xs[i], ys[i], done);
      end
    end
  endtask

  task automatic test_start_held();
    int cyc, bcyc;
    logic [2*W-1:0] pr;
    run_op(4'd7, 4'd9, 1'b1, cyc, bcyc, pr);
    start = 1'b0;
    checks++;
    if (cyc != W || pr !== 8'd63) begin
      failures++;
      $display("[TB] FAIL start_held: got p=%0d after %0d cycles, required p=63 after %0d", pr, cyc, W);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_held_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc, n;
    logic [2*W-1:0] pr;
    run_op(4'd2, 4'd7, 1'b0, cyc, bcyc, pr);
    checks++;
    if (pr !== 8'd14) begin
      failures++;
      $display("[TB] FAIL b2b_first: got %0d, required 14", pr);
    end
    x = 4'd3;
    y = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_accept: done=%b busy=%b, required done=0 busy=1", done, busy);
    end
    n = 0;
    while (n < 20) begin
      checks++;
      if (p !== 8'd14) begin
        failures++;
        $display("[TB] FAIL b2b_hold: p=%0d at cycle %0d, required 14", p, n);
      end
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    checks++;
    if (n != W || p !== 8'd15) begin
      failures++;
      $display("[TB] FAIL b2b_second: p=%0d after %0d cycles, required 15 after %0d", p, n, W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int cyc, bcyc;
    logic [2*W-1:0] pr;
    x = 4'd15;
    y = 4'd15;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || p === '0) begin
      failures++;
      $display("[TB] FAIL midrun_pre: busy=%b p=%0d, required busy=1 and nonzero p", busy, p);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
      failures++;
      $display("[TB] FAIL midrun_async_reset: busy=%b done=%b p=%0d, required 0 0 0", busy, done, p);
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midrun_no_done: done=%b busy=%b at cycle %0d, required 0 0", done, busy, i);
      end
    end
    run_op(4'd6, 4'd7, 1'b0, cyc, bcyc, pr);
    checks++;
    if (cyc != W || pr !== 8'd42) begin
      failures++;
      $display("[TB] FAIL midrun_recover: p=%0d after %0d cycles, required 42 after %0d", pr, cyc, W);
    end
  endtask

  task automatic test_random();
    int cyc, bcyc, gap, expected;
    logic [2*W-1:0] pr;
    logic [W-1:0] xv, yv;
    for (int i = 0; i < 16; i++) begin
      xv = W'($urandom_range(15));
      yv = W'($urandom_range(15));
      expected = int'(xv) * int'(yv);
      run_op(xv, yv, 1'b0, cyc, bcyc, pr);
      checks++;
      if (cyc != W || pr !== 8'(expected)) begin
        failures++;
        $display("[TB] FAIL random_op %0d*%0d: p=%0d after %0d cycles, required %0d after %0d", xv, yv, pr, cyc, expected, W);
      end
      gap = $urandom_range(3);
      for (int g = 0; g <= gap; g++) begin
        x = W'($urandom);
        y = W'($urandom);
        @(posedge clk);
        #1;
        checks++;
        if (p !== 8'(expected) || done !== 1'b0) begin
          failures++;
          $display("[TB] FAIL random_idle_hold: p=%0d done=%b, required p=%0d done=0", p, done, expected);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int n, expected;
    x = '0;
    y = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      expected = (i / 16) * (i % 16);
      n = 0;
      while (n < 20) begin
        @(posedge clk);
        #1;
        n++;
        if (done) break;
      end
      checks++;
      if (n != W || p !== 8'(expected)) begin
        failures++;
        $display("[TB] FAIL sweep %0d*%0d: p=%0d after %0d cycles, required %0d after %0d", i / 16, i % 16, p, n, expected, W);
      end
      if (i < 255) begin
        x = W'((i + 1) / 16);
        y = W'((i + 1) % 16);
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL sweep_done_width %0d*%0d: done=%b, required 0", i / 16, i % 16, done);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
